uart_depacketizer: RTL and testbench

UART_DEPACKETIZER -- requirements
Module: uart_depacketizer

---
 rtl/uart_depacketizer.sv | 259 +++++++++++++++++++++++++
 tb/tb_uart_depacketizer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_depacketizer.sv
// uart_depacketizer: UART receiver feeding a first-word-fall-through receive FIFO.
//
// Serial frames (start, DATA_BITS data LSB first, optional even parity, stop) are
// sampled mid-bit from a two-flop synchronised copy of serial_in. Good bytes are
// pushed into a 2**FIFO_ADDR_WIDTH entry FIFO whose head is always on data_out.
//
// Optional feature: define UART_RX_PARITY_EN to expect one even-parity bit per
// frame. Without it, frames are 8N1 and parity_error is tied low.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   serial_in     asynchronous UART line, idle high
//   rx_ready      consumer takes data_out this cycle (ignored while data_valid is low)
//   data_out      head-of-FIFO byte, zero while the FIFO is empty
//   data_valid    FIFO not empty
//   fifo_full     FIFO holds 2**FIFO_ADDR_WIDTH bytes
//   rx_busy       receiver is inside a frame
//   framing_error one-cycle pulse: stop bit sampled low
//   overrun       one-cycle pulse: good byte dropped because the FIFO was full
//   parity_error  one-cycle pulse: parity bit mismatch
module uart_depacketizer #(
  parameter int unsigned CLK_FREQ        = 50_000_000,
  parameter int unsigned BAUD_RATE       = 115200,
  parameter int unsigned DATA_BITS       = 8,
  parameter int unsigned FIFO_ADDR_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 fifo_full,
  output logic                 rx_busy,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 parity_error
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HalfBit    = ClksPerBit / 2;
  localparam int unsigned CntW       = $clog2(ClksPerBit + 1);
  localparam int unsigned IdxW       = $clog2(DATA_BITS + 1);
  localparam int unsigned Depth      = 2 ** FIFO_ADDR_WIDTH;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Reset to the idle level so release never looks like a
  // start edge.
  // ---------------------------------------------------------------------------
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic start_edge;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= serial_in;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  assign start_edge = rx_prev_q & ~rx_sync_q;

  // ---------------------------------------------------------------------------
  // Receiver FSM
  // ---------------------------------------------------------------------------
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  bit_done, half_done;
  logic                  stop_sample;
  logic                  par_bad;

`ifdef UART_RX_PARITY_EN
  logic par_bad_q, par_bad_d;
  logic par_err_q, par_err_d;
`endif

  assign bit_done  = (cnt_q == CntW'(ClksPerBit - 1));
  assign half_done = (cnt_q == CntW'(HalfBit - 1));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    idx_d       = idx_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
    par_err_d   = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start_edge) begin
          state_d = StStart;
        end
      end
      StStart: begin
        // Mid-start check rejects short low glitches on the idle line.
        if (half_done) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_sync_q ? StIdle : StData;
        end
      end
      StData: begin
        if (bit_done) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[DATA_BITS-1:1]};
          if (idx_q == IdxW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StParity: begin
`ifdef UART_RX_PARITY_EN
        if (bit_done) begin
          cnt_d     = '0;
          // Even parity: data bits plus parity bit carry an even number of ones.
          par_bad_d = rx_sync_q ^ (^shift_q);
          par_err_d = par_bad_d;
          state_d   = StStop;
        end
`else
        state_d = StIdle;
`endif
      end
      StStop: begin
        // Leave at mid-stop so a following start bit is never missed.
        if (bit_done) begin
          stop_sample = 1'b1;
          cnt_d       = '0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bad_q <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_bad_q <= par_bad_d;
      par_err_q <= par_err_d;
    end
  end

  assign par_bad      = par_bad_q;
  assign parity_error = par_err_q;
`else
  assign par_bad      = 1'b0;
  assign parity_error = 1'b0;
`endif

  assign rx_busy = (state_q != StIdle);

  // ---------------------------------------------------------------------------
  // Stop-bit outcome and status pulses
  // ---------------------------------------------------------------------------
  logic push, pop;
  logic framing_q, framing_d;
  logic overrun_q, overrun_d;

  // fifo_full reflects the count before this cycle's pop, so a push at full is
  // dropped even when the consumer frees a slot in the same cycle.
  assign push      = stop_sample & rx_sync_q & ~par_bad & ~fifo_full;
  assign pop       = data_valid & rx_ready;
  assign framing_d = stop_sample & ~rx_sync_q;
  assign overrun_d = stop_sample & rx_sync_q & ~par_bad & fifo_full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      framing_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      framing_q <= framing_d;
      overrun_q <= overrun_d;
    end
  end

  assign framing_error = framing_q;
  assign overrun       = overrun_q;

  // ---------------------------------------------------------------------------
  // Receive FIFO, first-word-fall-through
  // ---------------------------------------------------------------------------
  logic [DATA_BITS-1:0]       mem_q [Depth];
  logic [FIFO_ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_WIDTH:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointers are exactly FIFO_ADDR_WIDTH wide, so they wrap modulo the depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // Storage needs no reset: data_out is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign data_valid = (count_q != '0);
  assign fifo_full  = (count_q == (FIFO_ADDR_WIDTH + 1)'(Depth));
  assign data_out   = data_valid ? mem_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_uart_depacketizer.sv
// Directed bench for uart_depacketizer. Expected bytes are queued when a frame
// is sent and compared as the consumer pops them; flag pulses are counted.
// The bit rate is raised above the default so the run stays short, while the
// half-bit point stays well beyond the 100-clock glitch.
module tb_uart_depacketizer;

  localparam int unsigned CLK_FREQ  = 50_000_000;
  localparam int unsigned BAUD_RATE = 200_000;
  localparam int unsigned CPB       = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       serial_in = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] data_out;
  logic       data_valid, fifo_full, rx_busy, framing_error, overrun, parity_error;

  uart_depacketizer #(
    .CLK_FREQ       (CLK_FREQ),
    .BAUD_RATE      (BAUD_RATE),
    .DATA_BITS      (8),
    .FIFO_ADDR_WIDTH(4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .serial_in    (serial_in),
    .rx_ready     (rx_ready),
    .data_out     (data_out),
    .data_valid   (data_valid),
    .fifo_full    (fifo_full),
    .rx_busy      (rx_busy),
    .framing_error(framing_error),
    .overrun      (overrun),
    .parity_error (parity_error)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int pop_cnt = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, hold_bad = 0, lat_bad = 0;
  logic valid_prev = 1'b0, busy_prev = 1'b0, hold_prev = 1'b0;
  logic [7:0] out_prev = '0;
  int p0, f0, o0, e0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Per-cycle observation at the falling edge: scoreboard pops, flag pulse
  // counts, head stability while stalled, and push latency (data_valid must
  // rise in the same cycle the receiver drops back to idle).
  task automatic sample();
    if (!rst_n) begin
      valid_prev = 1'b0;
      busy_prev  = 1'b0;
      hold_prev  = 1'b0;
      return;
    end
    if (framing_error) fe_cnt++;
    if (overrun)       ov_cnt++;
    if (parity_error)  pe_cnt++;
    if (data_valid && !valid_prev && !(busy_prev && !rx_busy)) lat_bad++;
    if (hold_prev && data_valid && data_out !== out_prev) hold_bad++;
    if (data_valid && rx_ready) begin
      pop_cnt++;
      check("pop_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
    end
    hold_prev  = data_valid && !rx_ready;
    out_prev   = data_out;
    valid_prev = data_valid;
    busy_prev  = rx_busy;
  endtask

  task automatic tick();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic v, input int unsigned n);
    serial_in = v;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bits(b[i], CPB);
`ifdef UART_RX_PARITY_EN
    send_bits(^b, CPB);
`endif
    send_bits(stop, CPB);
    serial_in = 1'b1;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] b, input logic par);
    send_bits(1'b0, CPB);
    for (int i = 0; i < 8; i++) send_bits(b[i], CPB);
    send_bits(par, CPB);
    send_bits(1'b1, CPB);
  endtask
`endif

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_out"}, 32'(data_out), 32'd0);
    check({tag, "_valid"},    32'(data_valid), 32'd0);
    check({tag, "_full"},     32'(fifo_full), 32'd0);
    check({tag, "_busy"},     32'(rx_busy), 32'd0);
    check({tag, "_fe"},       32'(framing_error), 32'd0);
    check({tag, "_ov"},       32'(overrun), 32'd0);
    check({tag, "_pe"},       32'(parity_error), 32'd0);
  endtask

  initial begin
    logic [7:0] partial;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (5) tick();

    // Single 0xA5 frame, consumer always ready
    p0 = pop_cnt;
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    repeat (10) tick();
    check("a5_pops", 32'(pop_cnt - p0), 32'd1);
    check("a5_queue_empty", 32'(exp_q.size()), 32'd0);
    check("a5_latency", 32'(lat_bad), 32'd0);
    check("a5_flags", 32'(fe_cnt + ov_cnt + pe_cnt), 32'd0);

    // 100-clock low glitch on an idle line
    p0 = pop_cnt;
    serial_in = 1'b0;
    repeat (50) tick();
    check("glitch_busy_mid", 32'(rx_busy), 32'd1);
    repeat (50) tick();
    serial_in = 1'b1;
    repeat (2 * CPB) tick();
    check("glitch_busy_end", 32'(rx_busy), 32'd0);
    check("glitch_valid", 32'(data_valid), 32'd0);
    check("glitch_pops", 32'(pop_cnt - p0), 32'd0);
    check("glitch_flags", 32'(fe_cnt + ov_cnt + pe_cnt), 32'd0);

    // 0x3C with the stop bit low
    p0 = pop_cnt;
    f0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (CPB) tick();
    check("fe_pulse", 32'(fe_cnt - f0), 32'd1);
    check("fe_pops", 32'(pop_cnt - p0), 32'd0);
    check("fe_valid", 32'(data_valid), 32'd0);
    check("fe_no_overrun", 32'(ov_cnt), 32'd0);

    // 17 back-to-back frames with the consumer stalled
    rx_ready = 1'b0;
    o0 = ov_cnt;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(8'(i));
      send_frame(8'(i), 1'b1);
      if (i == 14) check("fill15_not_full", 32'(fifo_full), 32'd0);
      if (i == 15) begin
        check("fill16_full", 32'(fifo_full), 32'd1);
        check("fill16_no_overrun", 32'(ov_cnt - o0), 32'd0);
      end
    end
    repeat (5) tick();
    check("fill17_overrun", 32'(ov_cnt - o0), 32'd1);
    check("fill17_full", 32'(fifo_full), 32'd1);
    check("fill_head", 32'(data_out), 32'h00);
    check("fill_head_stable", 32'(hold_bad), 32'd0);
    check("fill_latency", 32'(lat_bad), 32'd0);
    p0 = pop_cnt;
    rx_ready = 1'b1;
    repeat (20) tick();
    check("drain_pops", 32'(pop_cnt - p0), 32'd16);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    check("drain_not_full", 32'(fifo_full), 32'd0);
    check("drain_valid", 32'(data_valid), 32'd0);

    // Reset during bit 4 of a frame, with one byte waiting in the FIFO
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    repeat (5) tick();
    check("pre_reset_valid", 32'(data_valid), 32'd1);
    partial = 8'hF0;
    send_bits(1'b0, CPB);
    for (int i = 0; i < 4; i++) send_bits(partial[i], CPB);
    serial_in = partial[4];
    repeat (CPB / 2) tick();
    check("pre_reset_busy", 32'(rx_busy), 32'd1);
    #2;
    rst_n = 1'b0;
    serial_in = 1'b1;
    #1;
    check_reset_outputs("midframe_reset");
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rx_ready = 1'b1;
    repeat (2 * CPB) tick();
    check("post_reset_idle", 32'(rx_busy), 32'd0);
    p0 = pop_cnt;
    f0 = fe_cnt;
    o0 = ov_cnt;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    repeat (10) tick();
    check("5a_pops", 32'(pop_cnt - p0), 32'd1);
    check("5a_queue_empty", 32'(exp_q.size()), 32'd0);
    check("5a_flags", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);

`ifdef UART_RX_PARITY_EN
    // 0x07 carries three ones, so even parity requires a 1
    p0 = pop_cnt;
    e0 = pe_cnt;
    f0 = fe_cnt;
    send_frame_par(8'h07, 1'b0);
    repeat (10) tick();
    check("par_bad_pulse", 32'(pe_cnt - e0), 32'd1);
    check("par_bad_pops", 32'(pop_cnt - p0), 32'd0);
    check("par_bad_no_fe", 32'(fe_cnt - f0), 32'd0);
    p0 = pop_cnt;
    e0 = pe_cnt;
    exp_q.push_back(8'h07);
    send_frame_par(8'h07, 1'b1);
    repeat (10) tick();
    check("par_good_pops", 32'(pop_cnt - p0), 32'd1);
    check("par_good_no_pe", 32'(pe_cnt - e0), 32'd0);
    check("par_good_queue_empty", 32'(exp_q.size()), 32'd0);
`else
    e0 = 0;
    check("parity_tied_low", 32'(pe_cnt - e0), 32'd0);
`endif
    check("final_latency", 32'(lat_bad), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
